// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access encodings and decode helpers.
package mem_access_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NLANE = 4;

  typedef enum logic [2:0] {
    MEM_LB  = 3'd0,
    MEM_LBU = 3'd1,
    MEM_LH  = 3'd2,
    MEM_LHU = 3'd3,
    MEM_LW  = 3'd4,
    MEM_SB  = 3'd5,
    MEM_SH  = 3'd6,
    MEM_SW  = 3'd7
  } mem_op_e;

  function automatic logic is_store(input mem_op_e op);
    return op[2] && (op != MEM_LW);
  endfunction

  // Halfwords need an even address, words a multiple of four; bytes are always aligned.
  function automatic logic is_aligned(input mem_op_e op, input logic [1:0] off);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return ~off[0];
      MEM_LW, MEM_SW:          return off == 2'b00;
      default:                 return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/halfword out of a RAM word and sign/zero-extends it.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [XLEN-1:0] dout,
  input  logic [1:0]      offset,
  input  mem_op_e         op,
  output logic [XLEN-1:0] rdata
);

  logic [1:0]  lane;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    lane     = offset ^ {2{BIG_ENDIAN}};
    byte_val = dout[{lane, 3'b000} +: 8];
    half_val = (offset[1] ^ BIG_ENDIAN) ? dout[31:16] : dout[15:0];
    case (op)
      MEM_LB:  rdata = {{24{byte_val[7]}}, byte_val};
      MEM_LBU: rdata = {24'd0, byte_val};
      MEM_LH:  rdata = {{16{half_val[15]}}, half_val};
      MEM_LHU: rdata = {16'd0, half_val};
      default: rdata = dout;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: store lane enables, one-cycle load return with stall hold,
// and misaligned-access reporting.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic             stall_i,
  output logic [XLEN-1:0]  data_addr_o,
  output logic [XLEN-1:0]  din_o,
  output logic [NLANE-1:0] wren_o,
  input  logic [XLEN-1:0]  dout_i,
  output logic [XLEN-1:0]  rdata_o,
  output logic             rvalid_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  bad_addr_o
);

  mem_op_e         op;
  logic            attempt_c;
  logic            aligned_c;
  logic            accept_c;
  logic [1:0]      byte_lane;
  logic [NLANE-1:0] lane_mask;

  logic            pend_q;
  mem_op_e         op_q;
  logic [1:0]      off_q;
  logic            hold_v_q;
  logic [XLEN-1:0] hold_data_q;
  logic            misalign_q;
  logic [XLEN-1:0] bad_addr_q;
  logic [XLEN-1:0] align_data;

  assign op          = mem_op_e'(op_i);
  assign attempt_c   = req_i & ~stall_i;
  assign aligned_c   = is_aligned(op, addr_i[1:0]);
  // Gating with rst keeps the RAM write strobes quiet for the whole reset window.
  assign accept_c    = attempt_c & aligned_c & rst;
  assign byte_lane   = addr_i[1:0] ^ {2{BIG_ENDIAN}};
  assign data_addr_o = addr_i;

  // Store lane decode and data replication.
  always_comb begin
    lane_mask = '0;
    din_o     = wdata_i;
    case (op)
      MEM_SB: begin
        din_o     = {4{wdata_i[7:0]}};
        lane_mask = 4'b0001 << byte_lane;
      end
      MEM_SH: begin
        din_o     = {2{wdata_i[15:0]}};
        lane_mask = (addr_i[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
      end
      MEM_SW:  lane_mask = 4'b1111;
      default: lane_mask = '0;
    endcase
    wren_o = (accept_c && is_store(op)) ? lane_mask : '0;
  end

  mem_access_unit_load_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_load_align (
    .dout   (dout_i),
    .offset (off_q),
    .op     (op_q),
    .rdata  (align_data)
  );

  // Load tracking, stall hold and fault capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= 1'b0;
      op_q        <= MEM_LB;
      off_q       <= 2'b00;
      hold_v_q    <= 1'b0;
      hold_data_q <= '0;
      misalign_q  <= 1'b0;
      bad_addr_q  <= '0;
    end else begin
      pend_q <= accept_c & ~is_store(op);
      if (accept_c && !is_store(op)) begin
        op_q  <= op;
        off_q <= addr_i[1:0];
      end
      // The RAM word is only valid in the return cycle, so a stalled result is frozen here.
      if (hold_v_q) begin
        if (!stall_i) hold_v_q <= 1'b0;
      end else if (pend_q && stall_i) begin
        hold_v_q    <= 1'b1;
        hold_data_q <= align_data;
      end
      misalign_q <= attempt_c & ~aligned_c;
      if (attempt_c && !aligned_c) bad_addr_q <= addr_i;
    end
  end

  assign rvalid_o   = pend_q | hold_v_q;
  assign rdata_o    = hold_v_q ? hold_data_q : (pend_q ? align_data : '0);
  assign misalign_o = misalign_q;
  assign bad_addr_o = bad_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-addressed reference memory, word-wide RAM model.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam bit          BE   = 1'b1;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [2:0]  OP_LB = 3'd0, OP_LBU = 3'd1, OP_LH = 3'd2, OP_LHU = 3'd3,
                          OP_LW = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;

  typedef struct packed {
    logic        mis;
    logic [31:0] bad;
  } mis_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] addr_i = BASE;
  logic [31:0] wdata_i = 32'd0;
  logic        stall_i = 1'b0;
  logic [31:0] data_addr_o, din_o, dout_i, rdata_o, bad_addr_o;
  logic [3:0]  wren_o;
  logic        rvalid_o, misalign_o;

  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_bad = 32'd0;
  logic [31:0] exp_ld[$];
  mis_t        exp_mis[$];
  logic [7:0]  ref_mem [64];
  logic [31:0] ram [16];

  mem_access_unit #(.BIG_ENDIAN(BE)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .stall_i(stall_i), .data_addr_o(data_addr_o), .din_o(din_o),
    .wren_o(wren_o), .dout_i(dout_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .misalign_o(misalign_o), .bad_addr_o(bad_addr_o)
  );

  always #5 clk = ~clk;

  // Word-wide synchronous RAM with byte enables (mem_array port B).
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (wren_o[l]) ram[data_addr_o[5:2]][8*l +: 8] <= din_o[8*l +: 8];
    dout_i <= ram[data_addr_o[5:2]];
  end

  function automatic int unsigned op_size(input logic [2:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit op_store(input logic [2:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic bit op_aligned(input logic [2:0] op, input logic [31:0] a);
    return (a % op_size(op)) == 0;
  endfunction

  function automatic logic [1:0] lane_of(input logic [31:0] a);
    return BE ? 2'(3 - int'(a[1:0])) : a[1:0];
  endfunction

  function automatic logic [3:0] exp_wren(input logic [2:0] op, input logic [31:0] a);
    logic [3:0] m;
    m = 4'b0000;
    for (int i = 0; i < int'(op_size(op)); i++) m[lane_of(a + 32'(i))] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_din(input logic [2:0] op, input logic [31:0] wd);
    if (op_size(op) == 1) return {4{wd[7:0]}};
    if (op_size(op) == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic void ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int s;
    s = int'(op_size(op));
    for (int i = 0; i < s; i++)
      ref_mem[6'(a - BASE + 32'(i))] = BE ? 8'(wd >> (8*(s-1-i))) : 8'(wd >> (8*i));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v;
    int s;
    s = int'(op_size(op));
    v = 32'd0;
    for (int i = 0; i < s; i++) begin
      if (BE) v = (v << 8) | 32'(ref_mem[6'(a - BASE + 32'(i))]);
      else    v = v | (32'(ref_mem[6'(a - BASE + 32'(i))]) << (8*i));
    end
    if (op == OP_LB && v[7])  v[31:8]  = '1;
    if (op == OP_LH && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string nm, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h with no matching expectation at %0t", nm, act, $time);
  endtask

  // One cycle of stimulus; called just after a rising edge.
  task automatic drive(input logic r, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic st);
    bit att, acc;
    logic [3:0] ew;
    req_i = r; op_i = op; addr_i = a; wdata_i = wd; stall_i = st;
    att = r && !st && rst;
    acc = att && op_aligned(op, a);
    ew  = (acc && op_store(op)) ? exp_wren(op, a) : 4'b0000;
    #1;
    check("wren", 32'(wren_o), 32'(ew));
    if (ew != 4'b0000) check("din", din_o, exp_din(op, wd));
    check("data_addr", data_addr_o, a);
    @(posedge clk);
    if (acc && op_store(op))  ref_store(op, a, wd);
    if (acc && !op_store(op)) exp_ld.push_back(ref_load(op, a));
    if (att && !acc) last_bad = a;
    exp_mis.push_back('{mis: att && !acc, bad: last_bad});
    #1;
  endtask

  task automatic idle();
    drive(1'b0, OP_LW, BASE, 32'd0, 1'b0);
  endtask

  // Monitor: a load result is retired in the first unstalled cycle it is shown.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_mis.size() == 0) flag_fail("misalign_queue_empty", 32'(misalign_o));
      else begin
        mis_t m;
        m = exp_mis.pop_front();
        check("misalign", 32'(misalign_o), 32'(m.mis));
        check("bad_addr", bad_addr_o, m.bad);
      end
      if (rvalid_o) begin
        if (exp_ld.size() == 0) flag_fail("spurious_rvalid", rdata_o);
        else begin
          check("rdata", rdata_o, exp_ld[0]);
          if (!stall_i) void'(exp_ld.pop_front());
        end
      end else if (exp_ld.size() != 0) begin
        flag_fail("missing_rvalid", exp_ld[0]);
        void'(exp_ld.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic [2:0] rop;
    logic [31:0] ra;
    logic [3:0] w;
    logic [1:0] l;
    for (int a = 0; a < 64; a++) begin
      b = 8'($urandom);
      ref_mem[a] = b;
      l = lane_of(32'(a));
      w = 4'(a / 4);
      ram[w][{l, 3'b000} +: 8] = b;
    end

    // Reset state, including a store request that must not strobe the RAM.
    req_i = 1'b1; op_i = OP_SW; addr_i = BASE; wdata_i = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wren", 32'(wren_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_bad_addr", bad_addr_o, 32'd0);
    rst = 1'b1;
    exp_mis.push_back('{mis: 1'b0, bad: 32'd0});
    mon_en = 1'b1;

    // Byte store into lane 0, then a known word and all load flavours back-to-back.
    drive(1'b1, OP_SB, 32'h103, 32'h0000_00AB, 1'b0);
    drive(1'b1, OP_SW, 32'h100, 32'h80FF_1234, 1'b0);
    drive(1'b1, OP_LB,  32'h100, 32'd0, 1'b0);
    drive(1'b1, OP_LBU, 32'h100, 32'd0, 1'b0);
    drive(1'b1, OP_LH,  32'h102, 32'd0, 1'b0);
    drive(1'b1, OP_LHU, 32'h100, 32'd0, 1'b0);
    drive(1'b1, OP_LW,  32'h100, 32'd0, 1'b0);
    drive(1'b1, OP_SH,  32'h106, 32'h0000_BEEF, 1'b0);
    drive(1'b1, OP_LH,  32'h106, 32'd0, 1'b0);

    // Misaligned halfword load and word store.
    drive(1'b1, OP_LH, 32'h101, 32'd0, 1'b0);
    idle();
    drive(1'b1, OP_SW, 32'h102, 32'h1122_3344, 1'b0);
    idle();

    // Load held across a three-cycle stall while the RAM address wanders.
    drive(1'b1, OP_LW, 32'h100, 32'd0, 1'b0);
    drive(1'b1, OP_LW, 32'h104, 32'd0, 1'b1);
    drive(1'b1, OP_SW, 32'h108, 32'h5555_5555, 1'b1);
    drive(1'b1, OP_LB, 32'h10C, 32'd0, 1'b1);
    idle();
    idle();

    // Back-to-back loads followed by a word store.
    drive(1'b1, OP_LW, 32'h100, 32'd0, 1'b0);
    drive(1'b1, OP_LW, 32'h104, 32'd0, 1'b0);
    drive(1'b1, OP_SW, 32'h108, 32'hDEAD_BEEF, 1'b0);
    idle();

    // Reset in the cycle after a load accept discards the load.
    drive(1'b1, OP_LW, 32'h104, 32'd0, 1'b0);
    rst = 1'b0;
    exp_ld.delete();
    exp_mis.delete();
    last_bad = 32'd0;
    exp_mis.push_back('{mis: 1'b0, bad: 32'd0});
    #1;
    check("midrst_rdata", rdata_o, 32'd0);
    check("midrst_rvalid", 32'(rvalid_o), 32'd0);
    drive(1'b1, OP_SW, 32'h10C, 32'h0BAD_F00D, 1'b0);
    drive(1'b1, OP_LH, 32'h101, 32'd0, 1'b0);
    rst = 1'b1;
    idle();
    idle();

    // Randomized traffic with stalls and misaligned addresses.
    for (int n = 0; n < 600; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = BASE + 32'($urandom_range(0, 63));
      drive($urandom_range(0, 9) < 8, rop, ra, $urandom, $urandom_range(0, 4) == 0);
    end
    repeat (3) idle();

    mon_en = 1'b0;
    check("loads_outstanding", 32'(exp_ld.size()), 32'd0);
    for (int a = 0; a < 64; a++) begin
      l = lane_of(32'(a));
      w = 4'(a / 4);
      check("ram_byte", 32'(ram[w][{l, 3'b000} +: 8]), 32'(ref_mem[a]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
